// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, encodings and templates for the UART command parser
package uart_cmd_pkg;

    // ASCII bytes with framing or decoding meaning
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_EIGHT = 8'h38;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_GOTO  = 2'd3
    } cmd_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // Templates are right-aligned: the first character sits in the most significant used byte
    localparam logic [63:0] START_TMPL = 64'("START-");
    localparam logic [63:0] STOP_TMPL  = 64'("STOP-");
    localparam logic [63:0] GOTO_TMPL  = 64'("GOTO-N");

    localparam int START_LEN       = 6;
    localparam int STOP_LEN        = 5;
    localparam int GOTO_PREFIX_LEN = 6;
    localparam int GOTO_LEN        = 8;
    localparam int GOTO_DIGIT_POS  = 6;

endpackage

// File: rtl/uart_cmd_match.sv
// rtl/uart_cmd_match.sv - combinational matcher of a collected frame against the command set
module uart_cmd_match
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 12,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [8*MAX_LEN-1:0] buffer,
    input  logic [CNT_W-1:0]     count,
    output logic                 match,
    output logic [1:0]           code,
    output logic [3:0]           node
);

    localparam int BW = 8 * MAX_LEN;

    // Place a right-aligned template into buffer layout (first character in byte 0)
    function automatic logic [BW-1:0] lay_out(input logic [63:0] tmpl, input int len);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if (j < len) begin
                r[j*8 +: 8] = tmpl[(len-1-j)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Mask selecting the first len bytes of the buffer
    function automatic logic [BW-1:0] byte_mask(input int len);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if (j < len) begin
                r[j*8 +: 8] = 8'hFF;
            end
        end
        return r;
    endfunction

    localparam logic [BW-1:0] START_EXP  = lay_out(START_TMPL, START_LEN);
    localparam logic [BW-1:0] START_MASK = byte_mask(START_LEN);
    localparam logic [BW-1:0] STOP_EXP   = lay_out(STOP_TMPL, STOP_LEN);
    localparam logic [BW-1:0] STOP_MASK  = byte_mask(STOP_LEN);
    localparam logic [BW-1:0] GOTO_EXP   = lay_out(GOTO_TMPL, GOTO_PREFIX_LEN);
    localparam logic [BW-1:0] GOTO_MASK  = byte_mask(GOTO_PREFIX_LEN);

    logic [7:0] digit;
    logic [7:0] last;
    logic       start_hit;
    logic       stop_hit;
    logic       goto_hit;

    assign digit = buffer[GOTO_DIGIT_POS*8 +: 8];
    assign last  = buffer[(GOTO_LEN-1)*8 +: 8];

    assign start_hit = (count == CNT_W'(START_LEN))
                    && (((buffer ^ START_EXP) & START_MASK) == '0);
    assign stop_hit  = (count == CNT_W'(STOP_LEN))
                    && (((buffer ^ STOP_EXP) & STOP_MASK) == '0);
    assign goto_hit  = (count == CNT_W'(GOTO_LEN))
                    && (((buffer ^ GOTO_EXP) & GOTO_MASK) == '0)
                    && (digit >= ASCII_ZERO) && (digit <= ASCII_EIGHT)
                    && (last == ASCII_DASH);

    // Priority is irrelevant since lengths differ; node is the low nibble of the ASCII digit
    always_comb begin
        match = start_hit | stop_hit | goto_hit;
        code  = CMD_NONE;
        node  = 4'd0;
        if (start_hit) begin
            code = CMD_START;
        end else if (stop_hit) begin
            code = CMD_STOP;
        end else if (goto_hit) begin
            code = CMD_GOTO;
            node = digit[3:0];
        end
    end

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// rtl/uart_rx_cmd_parser.sv - assembles '#'-terminated UART frames and decodes host commands
module uart_rx_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN        = 12,
    parameter int TIMEOUT_CYCLES = 3125
) (
    input  logic       clk_3125KHz,
    input  logic       reset,
    input  logic [7:0] rx_msg,
    input  logic       rx_complete,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [3:0] target_node,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state;
    logic [CNT_W-1:0]     count;
    logic [TMR_W-1:0]     timer;
    logic [8*MAX_LEN-1:0] buffer;

    logic       is_hash;
    logic       is_crlf;
    logic       store_en;
    logic       timeout_hit;
    logic       m_match;
    logic [1:0] m_code;
    logic [3:0] m_node;

    assign is_hash     = (rx_msg == ASCII_HASH);
    assign is_crlf     = (rx_msg == ASCII_CR) || (rx_msg == ASCII_LF);
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // count is always 0 in IDLE, so the first byte of a frame lands in byte 0
    assign store_en = rx_complete && !is_hash
                   && (((state == ST_IDLE) && !is_crlf)
                    || ((state == ST_COLLECT) && (count < CNT_W'(MAX_LEN))));

    uart_cmd_match #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_match (
        .buffer (buffer),
        .count  (count),
        .match  (m_match),
        .code   (m_code),
        .node   (m_node)
    );

    // Frame byte storage; never cleared, validity is tracked by count alone
    always_ff @(posedge clk_3125KHz) begin
        if (store_en) begin
            buffer[count*8 +: 8] <= rx_msg;
        end
    end

    // Frame state machine with registered pulses, held command outputs and idle timeout
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            timer       <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= CMD_NONE;
            target_node <= 4'd0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (rx_complete) begin
                        if (is_hash) begin
                            frame_error <= 1'b1;
                        end else if (!is_crlf) begin
                            count <= CNT_W'(1);
                            state <= ST_COLLECT;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (rx_complete) begin
                        timer <= '0;
                        if (is_hash) begin
                            if (m_match) begin
                                cmd_valid <= 1'b1;
                                cmd_code  <= m_code;
                                if (m_code == CMD_GOTO) begin
                                    target_node <= m_node;
                                end
                            end else begin
                                frame_error <= 1'b1;
                            end
                            count <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (count < CNT_W'(MAX_LEN)) begin
                            count <= count + CNT_W'(1);
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (timeout_hit) begin
                        frame_error <= 1'b1;
                        timer       <= '0;
                        count       <= '0;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_DISCARD: begin
                    if (rx_complete) begin
                        timer <= '0;
                        if (is_hash) begin
                            frame_error <= 1'b1;
                            count       <= '0;
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        frame_error <= 1'b1;
                        timer       <= '0;
                        count       <= '0;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb/tb_uart_rx_cmd_parser.sv - self-checking bench: vector table, corner sequences, random frames vs model
`timescale 1ns/1ps
module tb_uart_rx_cmd_parser;

    localparam int MAX_LEN = 12;
    localparam int TIMEOUT = 3125;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_msg = 8'h00;
    logic       rx_complete = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] target_node;
    logic       frame_error;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: pending frame bytes and the expected outputs
    logic [7:0] m_q[$];
    int         m_idle = 0;
    logic       m_valid = 1'b0;
    logic       m_err = 1'b0;
    logic [1:0] m_code = 2'd0;
    logic [3:0] m_node = 4'd0;
    logic       m_busy = 1'b0;

    typedef struct {
        string      frame;
        logic       exp_valid;
        logic       exp_err;
        logic [1:0] exp_code;
        logic [3:0] exp_node;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[14];

    uart_rx_cmd_parser dut (
        .clk_3125KHz (clk),
        .reset       (reset),
        .rx_msg      (rx_msg),
        .rx_complete (rx_complete),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .target_node (target_node),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #160 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit q_is(input string s);
        if (m_q.size() != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (m_q[i] != s[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit q_is_goto();
        string p;
        p = "GOTO-N";
        if (m_q.size() != 8) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_q[i] != p[i]) return 1'b0;
        end
        return (m_q[7] == 8'h2D) && (m_q[6] >= 8'h30) && (m_q[6] <= 8'h38);
    endfunction

    // Frame-level model: bytes accumulate until '#', then the whole string is judged
    task automatic model_in(input logic v, input logic [7:0] b);
        logic [7:0] d;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!v) begin
            if (m_q.size() > 0) begin
                if (m_idle == TIMEOUT - 1) begin
                    m_err = 1'b1;
                    m_q.delete();
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end else begin
            m_idle = 0;
            if (b == 8'h23) begin
                if (m_q.size() == 0 || m_q.size() > MAX_LEN) begin
                    m_err = 1'b1;
                end else if (q_is("START-")) begin
                    m_valid = 1'b1;
                    m_code  = 2'd1;
                end else if (q_is("STOP-")) begin
                    m_valid = 1'b1;
                    m_code  = 2'd2;
                end else if (q_is_goto()) begin
                    m_valid = 1'b1;
                    m_code  = 2'd3;
                    d       = m_q[6] - 8'h30;
                    m_node  = d[3:0];
                end else begin
                    m_err = 1'b1;
                end
                m_q.delete();
            end else if (!(m_q.size() == 0 && (b == 8'h0D || b == 8'h0A))) begin
                m_q.push_back(b);
            end
        end
        m_busy = (m_q.size() > 0);
    endtask

    task automatic compare_model();
        check("model cmd_valid",   8'(cmd_valid),   8'(m_valid));
        check("model frame_error", 8'(frame_error), 8'(m_err));
        check("model cmd_code",    8'(cmd_code),    8'(m_code));
        check("model target_node", 8'(target_node), 8'(m_node));
        check("model busy",        8'(busy),        8'(m_busy));
    endtask

    // One clock: drive at negedge, sample at the following negedge
    task automatic step(input logic v, input logic [7:0] b);
        rx_complete = v;
        rx_msg      = b;
        @(posedge clk);
        @(negedge clk);
        rx_complete = 1'b0;
        model_in(v, b);
        compare_model();
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) begin
                repeat ($urandom_range(0, max_gap)) step(1'b0, 8'h00);
            end
            step(1'b1, s[i]);
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, " cmd_valid"},   8'(cmd_valid),   8'h00);
        check({tag, " frame_error"}, 8'(frame_error), 8'h00);
        check({tag, " cmd_code"},    8'(cmd_code),    8'h00);
        check({tag, " target_node"}, 8'(target_node), 8'h00);
        check({tag, " busy"},        8'(busy),        8'h00);
    endtask

    initial begin
        string s;
        string alpha;
        int    sel;

        vecs[0]  = '{"START-#",            1'b1, 1'b0, 2'd1, 4'd0, 1'b0};
        vecs[1]  = '{"GOTO-N5-#",          1'b1, 1'b0, 2'd3, 4'd5, 1'b0};
        vecs[2]  = '{"\r\n",               1'b0, 1'b0, 2'd3, 4'd5, 1'b0};
        vecs[3]  = '{"GOTO-N9-#",          1'b0, 1'b1, 2'd3, 4'd5, 1'b0};
        vecs[4]  = '{"AAAAAAAAAAAAA#",     1'b0, 1'b1, 2'd3, 4'd5, 1'b0};
        vecs[5]  = '{"STOP-#",             1'b1, 1'b0, 2'd2, 4'd5, 1'b0};
        vecs[6]  = '{"#",                  1'b0, 1'b1, 2'd2, 4'd5, 1'b0};
        vecs[7]  = '{"GOTO-N8-#",          1'b1, 1'b0, 2'd3, 4'd8, 1'b0};
        vecs[8]  = '{"start-#",            1'b0, 1'b1, 2'd3, 4'd8, 1'b0};
        vecs[9]  = '{"\nGOTO-N0-#",        1'b1, 1'b0, 2'd3, 4'd0, 1'b0};
        vecs[10] = '{"START#",             1'b0, 1'b1, 2'd3, 4'd0, 1'b0};
        vecs[11] = '{"AAAAAAAAAAAA#",      1'b0, 1'b1, 2'd3, 4'd0, 1'b0};
        vecs[12] = '{"STOP-\r#",           1'b0, 1'b1, 2'd3, 4'd0, 1'b0};
        vecs[13] = '{"GOTO-N:-#",          1'b0, 1'b1, 2'd3, 4'd0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_zero("reset");
        reset = 1'b0;

        // Table-driven frames, each also tracked cycle by cycle by the model
        foreach (vecs[k]) begin
            send_str(vecs[k].frame, 2);
            check($sformatf("vec%0d cmd_valid", k),   8'(cmd_valid),   8'(vecs[k].exp_valid));
            check($sformatf("vec%0d frame_error", k), 8'(frame_error), 8'(vecs[k].exp_err));
            check($sformatf("vec%0d cmd_code", k),    8'(cmd_code),    8'(vecs[k].exp_code));
            check($sformatf("vec%0d target_node", k), 8'(target_node), 8'(vecs[k].exp_node));
            check($sformatf("vec%0d busy", k),        8'(busy),        8'(vecs[k].exp_busy));
            step(1'b0, 8'h00);
        end

        // Timeout: TIMEOUT idle clocks after "STA" abort the frame once
        send_str("STA", 0);
        repeat (TIMEOUT - 1) step(1'b0, 8'h00);
        check("pre-timeout busy", 8'(busy), 8'h01);
        check("pre-timeout frame_error", 8'(frame_error), 8'h00);
        step(1'b0, 8'h00);
        check("timeout frame_error", 8'(frame_error), 8'h01);
        check("timeout busy", 8'(busy), 8'h00);
        step(1'b0, 8'h00);
        check("timeout pulse width", 8'(frame_error), 8'h00);

        // Byte arriving on the clock the timeout would fire keeps the frame alive
        send_str("STA", 0);
        repeat (TIMEOUT - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h52);
        check("late byte frame_error", 8'(frame_error), 8'h00);
        check("late byte busy", 8'(busy), 8'h01);
        send_str("T-#", 0);
        check("late byte cmd_valid", 8'(cmd_valid), 8'h01);
        check("late byte cmd_code", 8'(cmd_code), 8'h01);

        // Reset mid-frame discards "GOTO-" and clears outputs
        send_str("GOTO-N3-#", 0);
        send_str("GOTO-", 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_zero("mid-frame reset");
        reset  = 1'b0;
        m_q.delete();
        m_idle = 0;
        m_code = 2'd0;
        m_node = 4'd0;
        m_busy = 1'b0;
        send_str("-N2-#", 0);
        check("post-reset frame_error", 8'(frame_error), 8'h01);
        check("post-reset cmd_code", 8'(cmd_code), 8'h00);
        step(1'b0, 8'h00);

        // Randomized frames against the model
        alpha = "STARGOP-N0589\r\nx#";
        for (int f = 0; f < 250; f++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: s = "START-#";
                1: s = "STOP-#";
                2: s = $sformatf("GOTO-N%c-#", 8'(8'h30 + $urandom_range(0, 9)));
                3: begin
                    s = "";
                    repeat ($urandom_range(0, 15)) begin
                        s = $sformatf("%s%c", s, alpha[$urandom_range(0, alpha.len() - 1)]);
                    end
                    s = {s, "#"};
                end
                4: s = ($urandom_range(0, 1) == 0) ? "\r\nSTOP-#" : "\nSTART-#";
                default: begin
                    s = "GOTO-N3-#";
                    s.putc($urandom_range(0, 7), alpha[$urandom_range(0, alpha.len() - 1)]);
                end
            endcase
            send_str(s, 3);
            repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_parser.md
Name: uart_rx_cmd_parser

Overview:
- Receive-side counterpart of the bot's UART message sender.
- Consumes bytes from the UART receiver (one strobe per byte) and assembles ASCII command frames terminated by '#'.
- Decodes host commands (START, STOP, GOTO node) into registered control outputs for the path planner and line-follower controller.
- Flags malformed, oversized and timed-out frames.

Parameters:
- MAX_LEN, 12, frame buffer depth in bytes, excluding the '#' terminator.
- TIMEOUT_CYCLES, 3125, idle clocks inside a frame before abort (1 ms at 3.125 MHz).

Ports:
- clk_3125KHz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_msg  input  8  received byte; valid only while rx_complete is high
- rx_complete  input  1  one-cycle strobe, one per received byte
- cmd_valid  output  1  one-cycle pulse: new command decoded
- cmd_code  output  2  0 none, 1 START, 2 STOP, 3 GOTO; held until the next valid command
- target_node  output  4  node number of the last GOTO; held
- frame_error  output  1  one-cycle pulse: frame rejected
- busy  output  1  high while a frame is being collected or discarded

Behaviour:
- Reset: all outputs 0, state IDLE, byte count 0, timer 0. Reset mid-frame discards the partial frame with no pulse.
- Only bytes with rx_complete=1 are processed. At most one byte per clock.
- States:
  - IDLE: CR (0x0D) and LF (0x0A) are ignored. '#' (0x23) means empty frame: pulse frame_error. Any other byte is stored at buffer[0], count=1, go to COLLECT.
  - COLLECT:
    - Non-'#' byte with count<MAX_LEN: store at buffer[count], count+1.
    - Non-'#' byte with count==MAX_LEN: go to DISCARD.
    - '#': decode the buffer (count bytes), return to IDLE.
  - DISCARD: drop bytes. On '#': pulse frame_error, go to IDLE.
- Decode (exact, case-sensitive, exact length):
  - "START-" (6 bytes) -> code 1.
  - "STOP-" (5 bytes) -> code 2.
  - "GOTO-Nd-" (8 bytes), d in '0'..'8' -> code 3, target_node=d-0x30.
  - Anything else, including d outside '0'..'8', -> frame_error pulse; cmd_code and target_node unchanged.
- Latency: cmd_valid or frame_error is high in the cycle after the clock edge that sampled '#'. cmd_code and target_node update on that same edge. The two pulses are never high together.
- Timeout:
  - The timer runs only in COLLECT and DISCARD and clears on every accepted byte.
  - After TIMEOUT_CYCLES consecutive clocks with no byte: go to IDLE, pulse frame_error on the next cycle, clear count.
  - If a byte arrives in the same cycle the timeout would fire, the byte wins.
- busy = (state != IDLE), registered.
- Timer width: clog2(TIMEOUT_CYCLES+1). Count width: clog2(MAX_LEN+1). Buffer is not cleared between frames; only count defines validity.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: HASH 0x23, DASH 0x2D, CR, LF, digit '0'.
  - cmd_code values: CMD_NONE, CMD_START, CMD_STOP, CMD_GOTO.
  - State encoding: IDLE, COLLECT, DISCARD.
  - Command template strings.
- One sub-module, uart_cmd_match: purely combinational. Inputs are the buffer and count. Outputs are match, code and node. Keeps the FSM file small and lets the matcher be unit-tested alone.

Test Plan:
- Bytes "START-#" -> cmd_valid for 1 cycle after the '#' edge, cmd_code=1, frame_error never high.
- "GOTO-N5-#" then "\r\n" -> cmd_code=3, target_node=5, one cmd_valid. CR/LF produce no pulse and busy stays 0.
- "GOTO-N9-#" after a valid GOTO-N5 -> frame_error pulse, cmd_code=3 and target_node=5 unchanged.
- 13 'A' bytes then '#' -> busy high throughout, single frame_error on '#'. A following "STOP-#" gives cmd_code=2.
- "STA" then 3125 idle clocks -> frame_error exactly once, busy falls. Variant: a byte arrives on clock 3125 -> no abort.
- Reset asserted after "GOTO-" -> outputs 0, IDLE. "-N2-#" then gives frame_error, because the frame is "-N2-", not a valid command.
